// File: rtl/dot_product_scheduler_pkg.sv
// Shared types and default timing constants for the dot-product scheduler.
// The engine result is a signed 8.18 fixed-point value.
package dot_product_scheduler_pkg;

  localparam int RESULT_W       = 26;
  localparam int DEF_ROWS       = 28;
  localparam int DEF_ROW_CYCLES = 7;
  localparam int DEF_RESULT_LAT = 284;

  typedef logic signed [RESULT_W-1:0] result_t;

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    RUN,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/dot_product_scheduler_argmax_tracker.sv
// Running arg-max over the neuron results of one image; on equal values the
// earlier (lower-index) neuron is kept.
module argmax_tracker
  import dot_product_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       update_i,
  input  logic       first_i,
  input  logic [3:0] idx_i,
  input  result_t    value_i,
  output logic [3:0] max_idx_o,
  output result_t    max_val_o
);

  logic [3:0] idx_q, idx_d;
  result_t    val_q, val_d;
  logic       take;

  always_comb begin
    take  = first_i || (value_i > val_q);
    idx_d = idx_q;
    val_d = val_q;
    if (clear_i) begin
      idx_d = '0;
      val_d = '0;
    end else if (update_i && take) begin
      idx_d = idx_i;
      val_d = value_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      val_q <= '0;
    end else begin
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end

  assign max_idx_o = idx_q;
  assign max_val_o = val_q;

endmodule

// File: rtl/dot_product_scheduler.sv
// Sequences the dot-product engine through every output neuron of one image,
// captures each result and reports the winning class.
module dot_product_scheduler
  import dot_product_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int ROWS        = DEF_ROWS,
  parameter int ROW_CYCLES  = DEF_ROW_CYCLES,
  parameter int RESULT_LAT  = DEF_RESULT_LAT
) (
  input  logic       clk,
  input  logic       GlobalReset,
  input  logic       start,
  input  logic       abort,
  input  result_t    eng_value,
  output logic       eng_rst,
  output logic [3:0] neuron_idx,
  output logic [4:0] row_addr,
  output logic       busy,
  output logic       neuron_valid,
  output result_t    neuron_data,
  output logic       done,
  output logic [3:0] class_out,
  output result_t    max_value
);

  localparam int CNT_W = $clog2(RESULT_LAT + 1);
  localparam int SUB_W = $clog2(ROW_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [4:0]       row_q, row_d;
  logic [3:0]       idx_q, idx_d;
  result_t          data_q, data_d;
  logic [3:0]       class_q, class_d;
  result_t          maxv_q, maxv_d;

  logic             trk_clear, trk_update;
  logic [3:0]       trk_idx;
  result_t          trk_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    row_d      = row_q;
    idx_d      = idx_q;
    data_d     = data_q;
    class_d    = class_q;
    maxv_d     = maxv_q;
    trk_clear  = 1'b0;
    trk_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = ENG_RST;
          idx_d     = '0;
          cnt_d     = '0;
          sub_d     = '0;
          row_d     = '0;
          trk_clear = 1'b1;
        end
      end
      ENG_RST: begin
        state_d = RUN;
        cnt_d   = '0;
        sub_d   = '0;
        row_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Row address advances on sub-counter wrap instead of dividing cnt.
        if (sub_q == SUB_W'(ROW_CYCLES - 1)) begin
          sub_d = '0;
          if (row_q != 5'(ROWS - 1)) row_d = row_q + 5'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
        if (cnt_q == CNT_W'(RESULT_LAT - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d     = eng_value;
        trk_update = 1'b1;
        if (idx_q == 4'(NUM_NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          state_d = ENG_RST;
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          sub_d   = '0;
          row_d   = '0;
        end
      end
      DONE: begin
        class_d = trk_idx;
        maxv_d  = trk_val;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards whatever this cycle would have produced.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sub_d      = '0;
      row_d      = '0;
      idx_d      = idx_q;
      data_d     = data_q;
      class_d    = class_q;
      maxv_d     = maxv_q;
      trk_update = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      class_q <= '0;
      maxv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      class_q <= class_d;
      maxv_q  <= maxv_d;
    end
  end

  argmax_tracker u_tracker (
    .clk       (clk),
    .rst_n     (GlobalReset),
    .clear_i   (trk_clear),
    .update_i  (trk_update),
    .first_i   (idx_q == 4'd0),
    .idx_i     (idx_q),
    .value_i   (eng_value),
    .max_idx_o (trk_idx),
    .max_val_o (trk_val)
  );

  // neuron_data shows the live result while neuron_valid is up, then holds it.
  assign eng_rst      = (state_q == IDLE) || (state_q == ENG_RST);
  assign busy         = (state_q != IDLE);
  assign neuron_valid = (state_q == CAPTURE) && !abort;
  assign done         = (state_q == DONE) && !abort;
  assign neuron_idx   = idx_q;
  assign row_addr     = row_q;
  assign neuron_data  = (state_q == CAPTURE) ? eng_value : data_q;
  assign class_out    = class_q;
  assign max_value    = maxv_q;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Self-checking bench for dot_product_scheduler: an engine model releases each
// neuron's value exactly RESULT_LAT cycles after its reset, junk otherwise.
module tb_dot_product_scheduler;

  localparam int NN       = 10;
  localparam int RL       = 284;
  localparam int RC       = 7;
  localparam int NR       = 28;
  localparam int PER      = RL + 2;
  localparam int DONE_CYC = PER * NN + 1;
  localparam logic [25:0] JUNK = 26'h1ABCDEF;

  logic        clk;
  logic        GlobalReset;
  logic        start;
  logic        abort;
  logic [25:0] eng_value;
  logic        eng_rst;
  logic [3:0]  neuron_idx;
  logic [4:0]  row_addr;
  logic        busy;
  logic        neuron_valid;
  logic [25:0] neuron_data;
  logic        done;
  logic [3:0]  class_out;
  logic [25:0] max_value;

  int          n_cmp;
  int          n_mis;
  int          eng_cyc;
  logic [25:0] vals [16];
  logic [3:0]  last_cls;
  logic [25:0] last_max;

  dot_product_scheduler dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .start        (start),
    .abort        (abort),
    .eng_value    (eng_value),
    .eng_rst      (eng_rst),
    .neuron_idx   (neuron_idx),
    .row_addr     (row_addr),
    .busy         (busy),
    .neuron_valid (neuron_valid),
    .neuron_data  (neuron_data),
    .done         (done),
    .class_out    (class_out),
    .max_value    (max_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model: synchronous reset, result valid RL cycles after release.
  always @(posedge clk) begin
    if (eng_rst) eng_cyc <= 0;
    else         eng_cyc <= eng_cyc + 1;
  end

  assign eng_value = (eng_cyc == RL) ? vals[neuron_idx] : JUNK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_argmax(output logic [3:0] cls, output logic [25:0] mx);
    cls = 4'd0;
    mx  = vals[0];
    for (int i = 1; i < NN; i++) begin
      if ($signed(vals[i]) > $signed(mx)) begin
        cls = 4'(i);
        mx  = vals[i];
      end
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NN; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) vals[i] = vals[$urandom_range(0, i - 1)];
      else                                    vals[i] = 26'($urandom);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_busy"},         64'(busy),         64'(0));
    chk({pfx, "_eng_rst"},      64'(eng_rst),      64'(1));
    chk({pfx, "_neuron_idx"},   64'(neuron_idx),   64'(0));
    chk({pfx, "_row_addr"},     64'(row_addr),     64'(0));
    chk({pfx, "_neuron_valid"}, 64'(neuron_valid), 64'(0));
    chk({pfx, "_done"},         64'(done),         64'(0));
    chk({pfx, "_neuron_data"},  64'(neuron_data),  64'(0));
    chk({pfx, "_class_out"},    64'(class_out),    64'(0));
    chk({pfx, "_max_value"},    64'(max_value),    64'(0));
  endtask

  // One image; abort_at / busy_start_at are cycle numbers after the start edge (0 = unused).
  task automatic run_image(input int abort_at, input int busy_start_at);
    logic [3:0]  ecls;
    logic [25:0] emax;
    int          nval;
    int          n;
    int          ph;
    int          erow;
    logic        seen;
    ref_argmax(ecls, emax);
    nval = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
      if (cyc > 1) @(negedge clk);
      n  = (cyc - 1) / PER;
      ph = (cyc - 1) % PER;
      chk("busy",         64'(busy),         64'(1));
      chk("done",         64'(done),         64'(cyc == DONE_CYC));
      chk("eng_rst",      64'(eng_rst),      64'(cyc < DONE_CYC && ph == 0));
      chk("neuron_valid", 64'(neuron_valid), 64'(cyc < DONE_CYC && ph == PER - 1));
      if (cyc < DONE_CYC) begin
        chk("neuron_idx", 64'(neuron_idx), 64'(n));
        erow = (ph == 0) ? 0 : (ph - 1) / RC;
        if (erow > NR - 1) erow = NR - 1;
        chk("row_addr", 64'(row_addr), 64'(erow));
        if (neuron_valid) begin
          nval++;
          chk("neuron_data", 64'(neuron_data), 64'(vals[n]));
        end
      end
      start = (cyc == busy_start_at);
      if (cyc == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",         64'(busy),         64'(0));
        chk("abort_eng_rst",      64'(eng_rst),      64'(1));
        chk("abort_done",         64'(done),         64'(0));
        chk("abort_neuron_valid", 64'(neuron_valid), 64'(0));
        chk("abort_class_out",    64'(class_out),    64'(last_cls));
        chk("abort_max_value",    64'(max_value),    64'(last_max));
        seen = 1'b0;
        repeat (3 * PER) begin
          @(negedge clk);
          seen = seen | done | neuron_valid | busy;
        end
        chk("abort_quiet", 64'(seen), 64'(0));
        return;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy",    64'(busy),      64'(0));
    chk("idle_eng_rst", 64'(eng_rst),   64'(1));
    chk("class_out",    64'(class_out), 64'(ecls));
    chk("max_value",    64'(max_value), 64'(emax));
    chk("valid_count",  64'(nval),      64'(NN));
    last_cls = ecls;
    last_max = emax;
  endtask

  task automatic reset_midrun();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (700) @(negedge clk);
    @(posedge clk);
    #3 GlobalReset = 1'b0;
    #1 check_reset_state("midrun_rst");
    @(negedge clk);
    GlobalReset = 1'b1;
    last_cls = 4'd0;
    last_max = 26'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    GlobalReset = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    last_cls    = 4'd0;
    last_max    = 26'd0;
    for (int i = 0; i < 16; i++) vals[i] = 26'h0000100;

    #2 GlobalReset = 1'b0;
    #2 check_reset_state("rst");
    repeat (3) @(negedge clk);
    GlobalReset = 1'b1;

    // abort alone and abort together with start while idle
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    chk("idle_abort_start_busy",    64'(busy),    64'(0));
    chk("idle_abort_start_eng_rst", 64'(eng_rst), 64'(1));
    @(negedge clk);
    chk("idle_abort_start_busy2",   64'(busy),    64'(0));

    // constant engine value: winner is neuron 0
    run_image(0, 0);

    // signed compare and lower-index tie rule, plus a start while busy
    vals[0] = 26'(-1); vals[1] = 26'(-5); vals[2] = 26'd3; vals[3] = 26'd3;
    vals[4] = 26'd2;   vals[5] = 26'(-7); vals[6] = 26'd0; vals[7] = 26'd1;
    vals[8] = 26'(-2); vals[9] = 26'd3;
    run_image(0, 1500);

    // abort at neuron 4, cnt 100, then a fresh image from neuron 0
    load_random();
    run_image(1 + 4 * PER + 101, 0);
    load_random();
    run_image(0, 0);

    // asynchronous reset mid-run, then a fresh image
    load_random();
    reset_midrun();
    load_random();
    run_image(0, 0);

    for (int k = 0; k < 2; k++) begin
      load_random();
      run_image(0, int'($urandom_range(10, 2800)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dot_product_scheduler.md
DOT_PRODUCT_SCHEDULER -- requirements
Module: dot_product_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 10, the number of output neurons sequenced per image.
REQ-002 The block SHALL have parameter ROWS, default 28, the number of weight/pixel rows per dot product.
REQ-003 The block SHALL have parameter ROW_CYCLES, default 7, the engine cycles spent per row.
REQ-004 The block SHALL have parameter RESULT_LAT, default 284, the engine cycles from reset release to a valid result.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port GlobalReset, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, which requests classification of one image.
REQ-008 The block SHALL have port abort, input, 1 bit, which cancels the run in progress.
REQ-009 The block SHALL have port eng_value, input, 26 bits, the signed 8.18 engine result.
REQ-010 The block SHALL have port eng_rst, output, 1 bit, the active-high synchronous reset driven to the engine.
REQ-011 The block SHALL have port neuron_idx, output, 4 bits, the weight-bank select.
REQ-012 The block SHALL have port row_addr, output, 5 bits, the pixel/weight row address.
REQ-013 The block SHALL have port busy, output, 1 bit, high while the block is outside IDLE.
REQ-014 The block SHALL have port neuron_valid, output, 1 bit, a 1-cycle pulse qualifying neuron_data.
REQ-015 The block SHALL have port neuron_data, output, 26 bits, the captured result of the neuron given by neuron_idx.
REQ-016 The block SHALL have port done, output, 1 bit, a 1-cycle end-of-image pulse.
REQ-017 The block SHALL have port class_out, output, 4 bits, the index of the winning neuron.
REQ-018 The block SHALL have port max_value, output, 26 bits, the value of the winning neuron.

Function
REQ-019 The FSM SHALL have states IDLE, ENG_RST, RUN, CAPTURE and DONE.
REQ-020 In IDLE, start=1 SHALL move the FSM to ENG_RST with neuron_idx=0, clear the max tracker and leave class_out/max_value unchanged.
REQ-021 ENG_RST SHALL last exactly 1 cycle with eng_rst=1, cnt=0 and row_addr=0, then move to RUN.
REQ-022 In RUN, cnt SHALL increment each cycle, and after RESULT_LAT cycles the FSM SHALL move to CAPTURE.
REQ-023 In RUN, row_addr SHALL increment every ROW_CYCLES cycles from 0 and saturate at ROWS-1, using a mod-ROW_CYCLES sub-counter (no divider).
REQ-024 In CAPTURE, the block SHALL latch eng_value into neuron_data and assert neuron_valid for 1 cycle.
REQ-025 In CAPTURE, the tracker SHALL update on signed eng_value > max, or unconditionally for neuron 0; ties SHALL keep the lower index.
REQ-026 From CAPTURE, the FSM SHALL go to DONE if neuron_idx==NUM_NEURONS-1, otherwise increment neuron_idx and go to ENG_RST.
REQ-027 In DONE, the block SHALL copy the tracker to class_out/max_value, assert done for 1 cycle, then return to IDLE.
REQ-028 Each neuron SHALL take 1+RESULT_LAT+1 cycles; with defaults, done SHALL be high in cycle 2861 after the start-sampling edge.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 In any non-IDLE state, abort SHALL force IDLE next cycle with eng_rst=1 for that cycle, no done and no neuron_valid, and class_out/max_value unchanged.
REQ-031 If abort and start are sampled together in IDLE, start SHALL be ignored.
REQ-032 eng_rst SHALL be high in IDLE and low only in RUN/CAPTURE/DONE except as stated above.

Reset
REQ-033 GlobalReset=0 SHALL asynchronously force IDLE with cnt=0, neuron_idx=0, row_addr=0, eng_rst=1, busy=0, neuron_valid=0, done=0, neuron_data=0, class_out=0 and max_value=0.
REQ-034 Reset asserted mid-run SHALL discard all progress, and the first start after release SHALL begin at neuron 0.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the 26-bit fixed-point result type, and the default ROWS, ROW_CYCLES and RESULT_LAT constants.
REQ-036 The block SHALL contain one sub-module, argmax_tracker, holding the signed compare plus the max/index registers with clear and update inputs.

Verification
REQ-037 Bench SHALL pulse start with the engine model returning constant 0x0000100 -> done in cycle 2861, class_out=0, max_value=0x0000100.
REQ-038 Bench SHALL return neuron values -1,-5,3,3,2,... (26-bit signed) -> class_out=2 and max_value=3, confirming the signed compare and the lower-index tie rule.
REQ-039 Bench SHALL trace row_addr during one RUN -> 0 for cnt 0-6, 1 for cnt 7-13, 27 for cnt 189-283, and eng_rst high exactly 1 cycle between neurons.
REQ-040 Bench SHALL assert abort at neuron 4, cnt 100 -> IDLE next cycle with no done, prior class_out retained, and a new start beginning at neuron 0.
REQ-041 Bench SHALL pull GlobalReset low asynchronously mid-RUN -> all outputs at reset values before the next clock edge.
REQ-042 Bench SHALL pulse start while busy -> no effect, and exactly NUM_NEURONS neuron_valid pulses per image.
